context_save_unit: RTL and testbench

//  Responder side of the program counter's quantum-expiry handshake: on `stored` it saves the

---
 rtl/csu_pkg.sv | 26 ++
 rtl/ctx_addr_gen.sv | 19 +
 rtl/context_save_unit.sv | 210 +++++++++++++++++++++
 tb/tb_context_save_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/csu_pkg.sv
// rtl/csu_pkg.sv - shared types and constants for the context save unit
package csu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_RF,
        S_SAVE_PC,
        S_SAVE_ACK,
        S_RST_RD,
        S_RST_PC,
        S_RST_DONE,
        S_RST_ERR
    } csu_state_e;

    localparam int NREGS_DEF  = 32;
    localparam int NPROC_DEF  = 8;
    localparam int OFF_PC     = NREGS_DEF;
    localparam int ID_W       = $clog2(NPROC_DEF);
    localparam int RI_W       = $clog2(NREGS_DEF);

    // A slot must hold every GPR plus the PC word.
    function automatic bit stride_ok(input int nregs, input int stride);
        return stride >= nregs + 1;
    endfunction

endpackage

// File: rtl/ctx_addr_gen.sv
// rtl/ctx_addr_gen.sv - maps (slot id, word offset) to a data-memory word address
module ctx_addr_gen #(
    parameter int ADDR_W     = 12,
    parameter int ID_W       = 3,
    parameter int OFF_W      = 6,
    parameter int CTX_BASE   = 3072,
    parameter int CTX_STRIDE = 64
) (
    input  logic [ID_W-1:0]   id,
    input  logic [OFF_W-1:0]  off,
    output logic [ADDR_W-1:0] addr
);

    // All terms are cast to ADDR_W so the sum wraps mod 2^ADDR_W.
    always_comb begin
        addr = ADDR_W'(CTX_BASE) + ADDR_W'(id) * ADDR_W'(CTX_STRIDE) + ADDR_W'(off);
    end

endmodule

// File: rtl/context_save_unit.sv
// rtl/context_save_unit.sv - saves/restores a process context (GPRs + PC) to data memory
module context_save_unit
    import csu_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int NREGS      = NREGS_DEF,
    parameter int NPROC      = NPROC_DEF,
    parameter int CTX_BASE   = 3072,
    parameter int CTX_STRIDE = 64
) (
    input  logic                      ck,
    input  logic                      nReset,
    input  logic                      stored,
    input  logic [ADDR_W-1:0]         pc_saved,
    input  logic [$clog2(NPROC)-1:0]  proc_id,
    input  logic                      restore_req,
    input  logic [$clog2(NPROC)-1:0]  restore_id,
    output logic [$clog2(NREGS)-1:0]  rf_raddr,
    input  logic [DATA_W-1:0]         rf_rdata,
    output logic                      rf_we,
    output logic [$clog2(NREGS)-1:0]  rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      stored_OK,
    output logic                      restore_done,
    output logic [ADDR_W-1:0]         restore_pc,
    output logic                      ctx_err,
    output logic                      busy,
    output logic [NPROC-1:0]          ctx_valid
);

    localparam int IDW = $clog2(NPROC);
    localparam int RIW = $clog2(NREGS);
    localparam int IXW = $clog2(NREGS + 1);

    if (!stride_ok(NREGS, CTX_STRIDE)) begin : g_stride_check
        $error("context_save_unit: CTX_STRIDE must be >= NREGS+1");
    end

    csu_state_e        state, state_n;
    logic [IXW-1:0]    idx;
    logic [IDW-1:0]    cur_id;
    logic [ADDR_W-1:0] cur_pc;
    logic              save_pend, rst_pend;
    logic [IDW-1:0]    save_pend_id, rst_pend_id;
    logic [ADDR_W-1:0] save_pend_pc;
    logic [NPROC-1:0]  ctx_valid_q;
    logic [ADDR_W-1:0] restore_pc_q;
    logic [IXW-1:0]    off;
    logic [ADDR_W-1:0] slot_addr;

    // A live request on the port takes precedence over (and replaces) a pending one.
    logic              eff_save, eff_rst;
    logic [IDW-1:0]    eff_save_id, eff_rst_id;
    logic [ADDR_W-1:0] eff_save_pc;

    assign eff_save    = stored | save_pend;
    assign eff_save_id = stored ? proc_id : save_pend_id;
    assign eff_save_pc = stored ? pc_saved : save_pend_pc;
    assign eff_rst     = restore_req | rst_pend;
    assign eff_rst_id  = restore_req ? restore_id : rst_pend_id;

    always_ff @(posedge ck or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (eff_save) begin
                    state_n = S_SAVE_RF;
                end else if (eff_rst) begin
                    state_n = ctx_valid_q[eff_rst_id] ? S_RST_RD : S_RST_ERR;
                end
            end
            S_SAVE_RF:  if (idx == IXW'(NREGS - 1)) state_n = S_SAVE_PC;
            S_SAVE_PC:  state_n = S_SAVE_ACK;
            S_SAVE_ACK: state_n = S_IDLE;
            S_RST_RD:   if (idx == IXW'(NREGS - 1)) state_n = S_RST_PC;
            S_RST_PC:   state_n = S_RST_DONE;
            S_RST_DONE: state_n = S_IDLE;
            S_RST_ERR:  state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge nReset) begin
        if (!nReset) begin
            idx          <= '0;
            cur_id       <= '0;
            cur_pc       <= '0;
            save_pend    <= 1'b0;
            save_pend_id <= '0;
            save_pend_pc <= '0;
            rst_pend     <= 1'b0;
            rst_pend_id  <= '0;
            ctx_valid_q  <= '0;
            restore_pc_q <= '0;
        end else begin
            if (state == S_IDLE) begin
                idx <= '0;
                if (eff_save) begin
                    cur_id      <= eff_save_id;
                    cur_pc      <= eff_save_pc;
                    save_pend   <= 1'b0;
                    rst_pend    <= eff_rst;
                    rst_pend_id <= eff_rst_id;
                end else if (eff_rst) begin
                    cur_id   <= eff_rst_id;
                    rst_pend <= 1'b0;
                end
            end else begin
                if (stored) begin
                    save_pend    <= 1'b1;
                    save_pend_id <= proc_id;
                    save_pend_pc <= pc_saved;
                end
                if (restore_req) begin
                    rst_pend    <= 1'b1;
                    rst_pend_id <= restore_id;
                end
                if (state == S_SAVE_RF || state == S_RST_RD) begin
                    idx <= idx + IXW'(1);
                end
            end
            if (state == S_SAVE_PC) ctx_valid_q[cur_id] <= 1'b1;
            if (state == S_RST_DONE) restore_pc_q <= mem_rdata[ADDR_W-1:0];
            if (state == S_RST_ERR) restore_pc_q <= '0;
        end
    end

    // Restore reads run one cycle ahead of the RF writes: the word arriving now
    // belongs to the offset issued last cycle, hence rf_waddr = idx-1.
    always_comb begin
        rf_raddr     = '0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        off          = '0;
        stored_OK    = 1'b0;
        restore_done = 1'b0;
        ctx_err      = 1'b0;
        restore_pc   = restore_pc_q;
        case (state)
            S_SAVE_RF: begin
                rf_raddr  = idx[RIW-1:0];
                mem_we    = 1'b1;
                mem_wdata = rf_rdata;
                off       = idx;
            end
            S_SAVE_PC: begin
                mem_we    = 1'b1;
                mem_wdata = DATA_W'(cur_pc);
                off       = IXW'(NREGS);
            end
            S_SAVE_ACK: stored_OK = 1'b1;
            S_RST_RD: begin
                off      = idx;
                rf_we    = (idx >= IXW'(2));
                rf_waddr = RIW'(idx - IXW'(1));
                rf_wdata = mem_rdata;
            end
            S_RST_PC: begin
                off      = IXW'(NREGS);
                rf_we    = 1'b1;
                rf_waddr = RIW'(NREGS - 1);
                rf_wdata = mem_rdata;
            end
            S_RST_DONE: begin
                off          = IXW'(NREGS);
                restore_done = 1'b1;
                restore_pc   = mem_rdata[ADDR_W-1:0];
            end
            S_RST_ERR: begin
                restore_done = 1'b1;
                ctx_err      = 1'b1;
                restore_pc   = '0;
            end
            default: ;
        endcase
    end

    ctx_addr_gen #(
        .ADDR_W     (ADDR_W),
        .ID_W       (IDW),
        .OFF_W      (IXW),
        .CTX_BASE   (CTX_BASE),
        .CTX_STRIDE (CTX_STRIDE)
    ) u_addr_gen (
        .id   (cur_id),
        .off  (off),
        .addr (slot_addr)
    );

    assign mem_addr  = busy ? slot_addr : '0;
    assign busy      = (state != S_IDLE);
    assign ctx_valid = ctx_valid_q;

endmodule

// File: tb/tb_context_save_unit.sv
// tb/tb_context_save_unit.sv - directed self-checking bench for context_save_unit
module tb_context_save_unit;
    import csu_pkg::*;

    logic            ck = 1'b0;
    logic            nReset;
    logic            stored, restore_req;
    logic [11:0]     pc_saved;
    logic [ID_W-1:0] proc_id, restore_id;
    logic [RI_W-1:0] rf_raddr, rf_waddr;
    logic [31:0]     rf_rdata, rf_wdata, mem_wdata, mem_rdata;
    logic            rf_we, mem_we, stored_OK, restore_done, ctx_err, busy;
    logic [11:0]     mem_addr, restore_pc;
    logic [7:0]      ctx_valid;

    logic [31:0] mem [0:4095];
    logic [31:0] rf  [0:31];
    logic        rf_load;
    logic [31:0] rf_seed;
    int          total = 0, bad = 0;
    int          ok_cnt = 0, we_cnt = 0;

    always #5 ck = ~ck;

    context_save_unit dut (
        .ck(ck), .nReset(nReset), .stored(stored), .pc_saved(pc_saved), .proc_id(proc_id),
        .restore_req(restore_req), .restore_id(restore_id), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stored_OK(stored_OK), .restore_done(restore_done), .restore_pc(restore_pc),
        .ctx_err(ctx_err), .busy(busy), .ctx_valid(ctx_valid)
    );

    always @(posedge ck) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    assign rf_rdata = rf[rf_raddr];
    always @(posedge ck) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_seed + 32'(i);
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    always @(negedge ck) begin
        if (stored_OK) ok_cnt = ok_cnt + 1;
        if (mem_we || rf_we) we_cnt = we_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_rf(input logic [31:0] seed);
        @(negedge ck);
        rf_seed = seed;
        rf_load = 1'b1;
        @(negedge ck);
        rf_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge ck);
        nReset = 1'b0;
        @(negedge ck);
        @(negedge ck);
        nReset = 1'b1;
    endtask

    task automatic wait_ok(inout int n);
        int guard = 0;
        while (stored_OK !== 1'b1 && guard < 150) begin
            @(negedge ck);
            n++;
            guard++;
        end
    endtask

    task automatic wait_done(inout int n);
        int guard = 0;
        while (restore_done !== 1'b1 && guard < 150) begin
            @(negedge ck);
            n++;
            guard++;
        end
    endtask

    initial begin
        int n;
        int base_ok, base_we;
        nReset = 1'b0; stored = 1'b0; restore_req = 1'b0;
        pc_saved = '0; proc_id = '0; restore_id = '0;
        rf_load = 1'b0; rf_seed = '0;
        @(negedge ck);
        @(negedge ck);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_valid", 32'(ctx_valid), 0);
        check_eq("rst_mem_we", 32'(mem_we), 0);
        check_eq("rst_ok", 32'(stored_OK), 0);
        check_eq("rst_pc", 32'(restore_pc), 0);
        nReset = 1'b1;

        // 1: save slot 2
        load_rf(32'h1000);
        @(negedge ck);
        proc_id = 3'd2; pc_saved = 12'h0A5; stored = 1'b1;
        @(negedge ck);
        stored = 1'b0; n = 1;
        check_eq("t1_busy", 32'(busy), 1);
        wait_ok(n);
        check_eq("t1_ok_cycle", n, 34);
        check_eq("t1_valid", 32'(ctx_valid), 32'h04);
        @(negedge ck);
        check_eq("t1_ok_one", 32'(stored_OK), 0);
        check_eq("t1_idle", 32'(busy), 0);
        for (int i = 0; i < 32; i++) check_eq($sformatf("t1_mem%0d", i), mem[3200 + i], 32'h1000 + 32'(i));
        check_eq("t1_mem_pc", mem[3200 + OFF_PC], 32'h0A5);

        // 2: clobber RF and restore slot 2
        load_rf(32'hDEAD0000);
        @(negedge ck);
        restore_id = 3'd2; restore_req = 1'b1;
        @(negedge ck);
        restore_req = 1'b0; n = 1;
        wait_done(n);
        check_eq("t2_done_cycle", n, 34);
        check_eq("t2_pc", 32'(restore_pc), 32'h0A5);
        check_eq("t2_err", 32'(ctx_err), 0);
        check_eq("t2_r0", rf[0], 32'hDEAD0000);
        for (int i = 1; i < 32; i++) check_eq($sformatf("t2_rf%0d", i), rf[i], 32'h1000 + 32'(i));
        @(negedge ck);
        check_eq("t2_pc_hold", 32'(restore_pc), 32'h0A5);
        check_eq("t2_idle", 32'(busy), 0);

        // 3: restore of an empty slot
        base_we = we_cnt;
        restore_id = 3'd5; restore_req = 1'b1;
        @(negedge ck);
        restore_req = 1'b0;
        check_eq("t3_done", 32'(restore_done), 1);
        check_eq("t3_err", 32'(ctx_err), 1);
        check_eq("t3_pc", 32'(restore_pc), 0);
        @(negedge ck);
        check_eq("t3_idle", 32'(busy), 0);
        check_eq("t3_done_one", 32'(restore_done), 0);
        #1;
        check_eq("t3_no_we", we_cnt - base_we, 0);

        // 4: save and restore of slot 3 on the same edge
        load_rf(32'h2000);
        @(negedge ck);
        proc_id = 3'd3; pc_saved = 12'h123; stored = 1'b1;
        restore_id = 3'd3; restore_req = 1'b1;
        @(negedge ck);
        stored = 1'b0; restore_req = 1'b0; n = 1;
        wait_ok(n);
        check_eq("t4_ok_cycle", n, 34);
        @(negedge ck);
        n++;
        check_eq("t4_gap_idle", 32'(busy), 0);
        wait_done(n);
        check_eq("t4_done_cycle", n, 69);
        check_eq("t4_err", 32'(ctx_err), 0);
        check_eq("t4_pc", 32'(restore_pc), 32'h123);
        check_eq("t4_mem_pc", mem[3264 + OFF_PC], 32'h123);

        // 5: reset in the middle of a save
        load_rf(32'h3000);
        @(negedge ck);
        #1 base_ok = ok_cnt;
        proc_id = 3'd6; pc_saved = 12'h077; stored = 1'b1;
        @(negedge ck);
        stored = 1'b0; n = 1;
        repeat (9) begin @(negedge ck); n++; end
        check_eq("t5_busy_c10", 32'(busy), 1);
        nReset = 1'b0;
        #1;
        check_eq("t5_async_busy", 32'(busy), 0);
        check_eq("t5_async_we", 32'(mem_we), 0);
        check_eq("t5_async_valid", 32'(ctx_valid), 0);
        repeat (2) @(negedge ck);
        nReset = 1'b1;
        repeat (40) @(negedge ck);
        #1;
        check_eq("t5_no_ok", ok_cnt - base_ok, 0);
        @(negedge ck);
        stored = 1'b1;
        @(negedge ck);
        stored = 1'b0; n = 1;
        wait_ok(n);
        check_eq("t5_ok_cycle", n, 34);
        check_eq("t5_valid", 32'(ctx_valid), 32'h40);
        check_eq("t5_mem_pc", mem[3456 + OFF_PC], 32'h077);

        // 6: second save request arrives while the first is running
        do_reset();
        load_rf(32'h4000);
        @(negedge ck);
        #1 base_ok = ok_cnt;
        proc_id = 3'd2; pc_saved = 12'h0B0; stored = 1'b1;
        @(negedge ck);
        stored = 1'b0; n = 1;
        repeat (4) begin @(negedge ck); n++; end
        proc_id = 3'd7; pc_saved = 12'h0C7; stored = 1'b1;
        @(negedge ck);
        stored = 1'b0; n++;
        wait_ok(n);
        check_eq("t6_ok1_cycle", n, 34);
        @(negedge ck);
        n++;
        wait_ok(n);
        check_eq("t6_ok2_cycle", n, 69);
        @(negedge ck);
        #1;
        check_eq("t6_ok_count", ok_cnt - base_ok, 2);
        check_eq("t6_valid", 32'(ctx_valid), 32'h84);
        check_eq("t6_mem_pc2", mem[3200 + OFF_PC], 32'h0B0);
        check_eq("t6_mem_pc7", mem[3520 + OFF_PC], 32'h0C7);
        check_eq("t6_mem7_r5", mem[3520 + 5], 32'h4005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
